// File: rtl/fxp_pkg.sv
// Shared fixed-point definitions for the arithmetic unit (multiplier, divider).
// Operand format defaults, sequencer state encoding and the saturation value.
package fxp_pkg;

    localparam int DEF_WIDTH = 10;
    localparam int DEF_FRAC  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } fxp_state_t;

    localparam logic [DEF_WIDTH-1:0] SAT_ALL_ONES = {DEF_WIDTH{1'b1}};

endpackage

// File: rtl/mul_datapath.sv
// Shift-and-add datapath: multiplicand/multiplier shift registers and accumulator.
// Exposes the saturated result of the accumulator value being written this cycle.
module mul_datapath
    import fxp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int FRAC  = DEF_FRAC
) (
    input  logic             clk,
    input  logic             sclr,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] q_next,
    output logic             ovf_next
);

    localparam int PW = 2 * WIDTH;

    logic [PW-1:0]    mcand;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    acc_nxt;
    logic [WIDTH-1:0] mplier;

    // Operand capture on load, one multiplier bit consumed per step
    always_ff @(posedge clk) begin
        if (sclr) begin
            mcand  <= {PW{1'b0}};
            acc    <= {PW{1'b0}};
            mplier <= {WIDTH{1'b0}};
        end else if (load) begin
            mcand  <= {{WIDTH{1'b0}}, a_in};
            acc    <= {PW{1'b0}};
            mplier <= b_in;
        end else if (step) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end else begin
            mcand  <= mcand;
            acc    <= acc;
            mplier <= mplier;
        end
    end

    // Conditional add, then overflow detection and truncating slice of the product
    always_comb begin
        acc_nxt  = acc;
        ovf_next = 1'b0;
        q_next   = {WIDTH{1'b0}};
        if (mplier[0]) begin
            acc_nxt = acc + mcand;
        end else begin
            acc_nxt = acc;
        end
        ovf_next = |acc_nxt[PW-1:WIDTH+FRAC];
        if (ovf_next) begin
            q_next = {WIDTH{1'b1}};
        end else begin
            q_next = acc_nxt[WIDTH+FRAC-1:FRAC];
        end
    end

endmodule

// File: rtl/multiplier.sv
// Sequential unsigned Q(WIDTH-FRAC).FRAC multiplier with start/busy/valid handshake.
// Holds the sequencer FSM and iteration counter; arithmetic lives in mul_datapath.
module multiplier
    import fxp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int FRAC  = DEF_FRAC
) (
    input  logic             clk,
    input  logic             sclr,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             start,
    output logic [WIDTH-1:0] q_out,
    output logic             ovf,
    output logic             busy,
    output logic             valid
);

    localparam int CNT_W = $clog2(WIDTH);

    fxp_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             load;
    logic             step;
    logic             last;
    logic [WIDTH-1:0] q_next;
    logic             ovf_next;

    // Datapath controls decoded from the current state
    always_comb begin
        load = 1'b0;
        step = 1'b0;
        last = 1'b0;
        if (state == CALC) begin
            step = 1'b1;
            last = (cnt == CNT_W'(WIDTH - 1));
        end else begin
            load = start;
        end
    end

    mul_datapath #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_datapath (
        .clk      (clk),
        .sclr     (sclr),
        .load     (load),
        .step     (step),
        .a_in     (a_in),
        .b_in     (b_in),
        .q_next   (q_next),
        .ovf_next (ovf_next)
    );

    // Sequencer FSM; results are registered on the final step so valid coincides with DONE
    always_ff @(posedge clk) begin
        if (sclr) begin
            state <= IDLE;
            cnt   <= {CNT_W{1'b0}};
            q_out <= {WIDTH{1'b0}};
            ovf   <= 1'b0;
            busy  <= 1'b0;
            valid <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    valid <= 1'b0;
                    cnt   <= {CNT_W{1'b0}};
                    if (start) begin
                        state <= CALC;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                CALC: begin
                    cnt <= cnt + CNT_W'(1);
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        valid <= 1'b1;
                        q_out <= q_next;
                        ovf   <= ovf_next;
                    end else begin
                        state <= CALC;
                        busy  <= 1'b1;
                        valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= {CNT_W{1'b0}};
                    busy  <= 1'b0;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier.sv
// Directed table-driven bench for multiplier, plus hand sequences for
// operand hold, back-to-back starts and synchronous clear mid-computation.
module tb_multiplier;

    logic       clk;
    logic       sclr;
    logic [9:0] a_in;
    logic [9:0] b_in;
    logic       start;
    logic [9:0] q_out;
    logic       ovf;
    logic       busy;
    logic       valid;

    int total;
    int bad;

    typedef struct {
        logic [9:0] a;
        logic [9:0] b;
        logic [9:0] q;
        logic       o;
    } vec_t;

    vec_t vecs[10];

    multiplier dut (
        .clk   (clk),
        .sclr  (sclr),
        .a_in  (a_in),
        .b_in  (b_in),
        .start (start),
        .q_out (q_out),
        .ovf   (ovf),
        .busy  (busy),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    // Accept one operation, then watch busy length, result and single-cycle valid
    task automatic do_op(input logic [9:0] a, input logic [9:0] b,
                         input logic [9:0] eq, input logic eo, input string nm);
        int nb;
        bit got;
        nb  = 0;
        got = 1'b0;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a_in  = ~a;
        b_in  = ~b;
        for (int i = 0; i < 20 && !got; i++) begin
            if (valid) begin
                got = 1'b1;
            end else begin
                if (busy) nb++;
                @(negedge clk);
            end
        end
        check({nm, "_valid_seen"}, 32'(got), 32'd1);
        check({nm, "_busy_cycles"}, nb, 32'd10);
        check({nm, "_busy_at_valid"}, 32'(busy), 32'd0);
        check({nm, "_q"}, 32'(q_out), 32'(eq));
        check({nm, "_ovf"}, 32'(ovf), 32'(eo));
        @(negedge clk);
        check({nm, "_valid_pulse"}, 32'(valid), 32'd0);
        check({nm, "_q_held"}, 32'(q_out), 32'(eq));
    endtask

    initial begin
        int nvalid;
        int first_v;
        int second_v;
        bit overlap;
        logic [9:0] q_seen;

        total = 0;
        bad   = 0;
        sclr  = 1'b1;
        start = 1'b0;
        a_in  = 10'h000;
        b_in  = 10'h000;

        vecs[0] = '{10'h0C0, 10'h004, 10'h030, 1'b0};  // 12.0 * 0.25
        vecs[1] = '{10'h038, 10'h004, 10'h00E, 1'b0};  // 3.5 * 0.25
        vecs[2] = '{10'h280, 10'h020, 10'h3FF, 1'b1};  // 40.0 * 2.0 overflows
        vecs[3] = '{10'h3FF, 10'h010, 10'h3FF, 1'b0};  // max * 1.0 fits exactly
        vecs[4] = '{10'h001, 10'h001, 10'h000, 1'b0};  // truncated to zero
        vecs[5] = '{10'h3FF, 10'h011, 10'h3FF, 1'b1};  // just past the range
        vecs[6] = '{10'h000, 10'h3FF, 10'h000, 1'b0};
        vecs[7] = '{10'h3FF, 10'h000, 10'h000, 1'b0};
        vecs[8] = '{10'h025, 10'h013, 10'h02B, 1'b0};  // 703 >> 4
        vecs[9] = '{10'h3FF, 10'h3FF, 10'h3FF, 1'b1};

        @(negedge clk);
        @(negedge clk);
        sclr = 1'b0;
        check("rst_q", 32'(q_out), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].o, $sformatf("vec%0d", i));
        end

        // start held 5 cycles with operands changing while busy
        a_in  = 10'h0C0;
        b_in  = 10'h004;
        start = 1'b1;
        @(negedge clk);
        a_in  = 10'h3FF;
        b_in  = 10'h3FF;
        repeat (4) @(negedge clk);
        start  = 1'b0;
        nvalid = 0;
        q_seen = 10'h000;
        for (int i = 0; i < 25; i++) begin
            if (valid) begin
                nvalid++;
                q_seen = q_out;
            end
            @(negedge clk);
        end
        check("hold_nvalid", nvalid, 32'd1);
        check("hold_q", 32'(q_seen), 32'h030);

        // start held continuously: results every 11 cycles, never busy with valid
        a_in     = 10'h038;
        b_in     = 10'h004;
        start    = 1'b1;
        first_v  = -1;
        second_v = -1;
        overlap  = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            if (valid && busy) overlap = 1'b1;
            if (valid) begin
                if (first_v < 0) first_v = i;
                else if (second_v < 0) second_v = i;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("b2b_first", first_v, 32'd10);
        check("b2b_period", second_v - first_v, 32'd11);
        check("b2b_no_overlap", 32'(overlap), 32'd0);
        check("b2b_q", 32'(q_out), 32'h00E);
        repeat (15) @(negedge clk);

        // sclr five cycles into a computation discards it
        a_in  = 10'h280;
        b_in  = 10'h020;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        sclr = 1'b1;
        @(negedge clk);
        sclr = 1'b0;
        check("sclr_busy", 32'(busy), 32'd0);
        check("sclr_valid", 32'(valid), 32'd0);
        check("sclr_q", 32'(q_out), 32'd0);
        check("sclr_ovf", 32'(ovf), 32'd0);
        nvalid = 0;
        for (int i = 0; i < 15; i++) begin
            if (valid || busy) nvalid++;
            @(negedge clk);
        end
        check("sclr_quiet", nvalid, 32'd0);
        do_op(10'h0C0, 10'h004, 10'h030, 1'b0, "after_sclr");

        // sclr and start together: start dropped
        sclr  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        sclr  = 1'b0;
        start = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 15; i++) begin
            if (valid || busy) nvalid++;
            @(negedge clk);
        end
        check("sclr_start_dropped", nvalid, 32'd0);
        check("sclr_start_q", 32'(q_out), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
